// File: rtl/wisc_pkg.sv
// Shared WISC definitions: opcode map and flag-update classification.
package wisc_pkg;

    localparam int unsigned OPC_W = 4;

    localparam logic [OPC_W-1:0] OPC_ADD    = 4'h0;
    localparam logic [OPC_W-1:0] OPC_SUB    = 4'h1;
    localparam logic [OPC_W-1:0] OPC_XOR    = 4'h2;
    localparam logic [OPC_W-1:0] OPC_RED    = 4'h3;
    localparam logic [OPC_W-1:0] OPC_SLL    = 4'h4;
    localparam logic [OPC_W-1:0] OPC_SRA    = 4'h5;
    localparam logic [OPC_W-1:0] OPC_ROR    = 4'h6;
    localparam logic [OPC_W-1:0] OPC_PADDSB = 4'h7;
    localparam logic [OPC_W-1:0] OPC_LW     = 4'h8;
    localparam logic [OPC_W-1:0] OPC_SW     = 4'h9;
    localparam logic [OPC_W-1:0] OPC_LLB    = 4'hA;
    localparam logic [OPC_W-1:0] OPC_LHB    = 4'hB;
    localparam logic [OPC_W-1:0] OPC_B      = 4'hC;
    localparam logic [OPC_W-1:0] OPC_BR     = 4'hD;
    localparam logic [OPC_W-1:0] OPC_PCS    = 4'hE;
    localparam logic [OPC_W-1:0] OPC_HLT    = 4'hF;

    // Which architectural flags an opcode writes.
    typedef enum logic [1:0] {
        FC_NONE = 2'd0,
        FC_Z    = 2'd1,
        FC_ZVN  = 2'd2
    } flag_class_e;

    // Arithmetic ops write all flags; logic/shift ops write only Z.
    function automatic flag_class_e flag_class(input logic [OPC_W-1:0] opc);
        flag_class_e fc;
        fc = FC_NONE;
        case (opc)
            OPC_ADD, OPC_SUB:                   fc = FC_ZVN;
            OPC_XOR, OPC_SLL, OPC_SRA, OPC_ROR: fc = FC_Z;
            default:                            fc = FC_NONE;
        endcase
        return fc;
    endfunction

endpackage

// File: rtl/flag_reg.sv
// Architectural Z/V/N flag register with per-bit load enables.
module flag_reg (
    input  logic clk,
    input  logic rst_n,
    input  logic en_z,
    input  logic en_v,
    input  logic en_n,
    input  logic d_z,
    input  logic d_v,
    input  logic d_n,
    output logic q_z,
    output logic q_v,
    output logic q_n
);

    logic z_q, v_q, n_q;
    logic z_d, v_d, n_d;

    // Each flag reloads only when its own enable is set.
    always_comb begin
        z_d = z_q;
        v_d = v_q;
        n_d = n_q;
        if (en_z) z_d = d_z;
        if (en_v) v_d = d_v;
        if (en_n) n_d = d_n;
    end

    // Flag state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= 1'b0;
            v_q <= 1'b0;
            n_q <= 1'b0;
        end else begin
            z_q <= z_d;
            v_q <= v_d;
            n_q <= n_d;
        end
    end

    assign q_z = z_q;
    assign q_v = v_q;
    assign q_n = n_q;

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register with stall/flush and ownership of the Z/V/N flags.
module ex_mem_flag_stage
    import wisc_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [OPC_W-1:0]  ex_opcode,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_ovfl,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              ex_reg_wen,
    input  logic              ex_mem_ren,
    input  logic              ex_mem_wen,
    input  logic [DATA_W-1:0] ex_st_data,
    input  logic              ex_halt,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_result,
    output logic [REG_AW-1:0] mem_dst,
    output logic              mem_reg_wen,
    output logic              mem_mem_ren,
    output logic              mem_mem_wen,
    output logic [DATA_W-1:0] mem_st_data,
    output logic              mem_halt,
    output logic              flag_z,
    output logic              flag_v,
    output logic              flag_n,
    output logic              flag_pending
);

    logic              valid_q,   valid_d;
    logic [DATA_W-1:0] result_q,  result_d;
    logic [REG_AW-1:0] dst_q,     dst_d;
    logic              reg_wen_q, reg_wen_d;
    logic              mem_ren_q, mem_ren_d;
    logic              mem_wen_q, mem_wen_d;
    logic [DATA_W-1:0] st_data_q, st_data_d;
    logic              halt_q,    halt_d;

    flag_class_e fc;
    logic        load_flags;

    // Next-state mux: flush beats stall beats load; controls die with bubbles.
    always_comb begin
        valid_d   = valid_q;
        result_d  = result_q;
        dst_d     = dst_q;
        reg_wen_d = reg_wen_q;
        mem_ren_d = mem_ren_q;
        mem_wen_d = mem_wen_q;
        st_data_d = st_data_q;
        halt_d    = halt_q;
        if (flush) begin
            valid_d   = 1'b0;
            result_d  = '0;
            dst_d     = '0;
            reg_wen_d = 1'b0;
            mem_ren_d = 1'b0;
            mem_wen_d = 1'b0;
            st_data_d = '0;
            halt_d    = 1'b0;
        end else if (!stall) begin
            valid_d   = ex_valid;
            result_d  = ex_result;
            dst_d     = ex_dst;
            reg_wen_d = ex_reg_wen & ex_valid;
            mem_ren_d = ex_mem_ren & ex_valid;
            mem_wen_d = ex_mem_wen & ex_valid;
            st_data_d = ex_st_data;
            halt_d    = ex_halt & ex_valid;
        end
    end

    // Stage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            result_q  <= '0;
            dst_q     <= '0;
            reg_wen_q <= 1'b0;
            mem_ren_q <= 1'b0;
            mem_wen_q <= 1'b0;
            st_data_q <= '0;
            halt_q    <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            result_q  <= result_d;
            dst_q     <= dst_d;
            reg_wen_q <= reg_wen_d;
            mem_ren_q <= mem_ren_d;
            mem_wen_q <= mem_wen_d;
            st_data_q <= st_data_d;
            halt_q    <= halt_d;
        end
    end

    // Flags move only when a real instruction is actually loaded into the stage.
    always_comb begin
        fc         = flag_class(ex_opcode);
        load_flags = ex_valid & ~flush & ~stall;
    end

    flag_reg u_flag_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en_z  (load_flags & (fc != FC_NONE)),
        .en_v  (load_flags & (fc == FC_ZVN)),
        .en_n  (load_flags & (fc == FC_ZVN)),
        .d_z   (ex_result == '0),
        .d_v   (ex_ovfl),
        .d_n   (ex_result[DATA_W-1]),
        .q_z   (flag_z),
        .q_v   (flag_v),
        .q_n   (flag_n)
    );

    assign flag_pending = ex_valid & (fc != FC_NONE);

    assign mem_valid   = valid_q;
    assign mem_result  = result_q;
    assign mem_dst     = dst_q;
    assign mem_reg_wen = reg_wen_q;
    assign mem_mem_ren = mem_ren_q;
    assign mem_mem_wen = mem_wen_q;
    assign mem_st_data = st_data_q;
    assign mem_halt    = halt_q;

endmodule
